// File: rtl/adder_3_bit_accumulator_if.sv
// Bus between the adder stage / controller and the accumulator.
// It carries the start/done handshake, the result beat, and the running total.
interface adder_3_bit_accumulator_if #(
  parameter int ACC_WIDTH = 6,
  parameter int CNT_WIDTH = 4
);
  logic                 start;
  logic [CNT_WIDTH-1:0] num_samples;
  logic                 in_valid;
  logic [2:0]           S;
  logic                 Cout;
  logic                 in_ready;
  logic                 busy;
  logic [ACC_WIDTH-1:0] total;
  logic                 overflow;
  logic                 done;

  modport master (
    output start, num_samples, in_valid, S, Cout,
    input  in_ready, busy, total, overflow, done
  );

  modport slave (
    input  start, num_samples, in_valid, S, Cout,
    output in_ready, busy, total, overflow, done
  );
endinterface

// File: rtl/adder_3_bit_accumulator.sv
// Sums a programmed number of 4-bit adder results {Cout,S} into a wrapping total.
// The total register carries a sticky overflow flag and emits a one-cycle done pulse.
module adder_3_bit_accumulator #(
  parameter int ACC_WIDTH = 6,
  parameter int CNT_WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  adder_3_bit_accumulator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] counter, latched;
  logic [ACC_WIDTH-1:0] total;
  logic                 overflow;
  logic [ACC_WIDTH:0]   sum;
  logic                 last_beat;

  // One spare bit catches the carry out of the top of the total.
  assign sum       = {1'b0, total} + {{(ACC_WIDTH-3){1'b0}}, bus.Cout, bus.S};
  assign last_beat = (counter == latched - CNT_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = (bus.num_samples != '0) ? ACCUM : DONE;
      ACCUM:   if (bus.in_valid && last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total    <= '0;
      overflow <= 1'b0;
      counter  <= '0;
      latched  <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          total    <= '0;
          overflow <= 1'b0;
          if (bus.num_samples != '0) begin
            counter <= '0;
            latched <= bus.num_samples;
          end
        end
        ACCUM: if (bus.in_valid) begin
          total    <= sum[ACC_WIDTH-1:0];
          overflow <= overflow | sum[ACC_WIDTH];
          counter  <= counter + CNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready = (state == ACCUM);
  assign bus.busy     = (state == ACCUM);
  assign bus.done     = (state == DONE);
  assign bus.total    = total;
  assign bus.overflow = overflow;
endmodule
